sync_debounce: RTL and testbench
================================

SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 Parameter WIDTH, default 1: number of independent input channels, minimum 1.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth, minimum 2.
REQ-003 Parameter STABLE_CYCLES, default 4: enabled cycles of sustained mismatch needed before the filtered output flips, minimum 1.
REQ-004 Parameter CNT_W, default $clog2(STABLE_CYCLES+1): per-channel counter width, derived and not overridden.
REQ-005 clk  in  1  single clock; every flop in the block is clocked on its rising edge.
REQ-006 rst  in  1  reset, synchronous to clk and active-high.
REQ-007 async_in  in  WIDTH  asynchronous raw inputs, such as buttons or switches.
REQ-008 en  in  1  debounce sample enable, such as a slow tick; tie it high for per-cycle operation.
REQ-009 sync_out  out  WIDTH  synchronized but unfiltered inputs.
REQ-010 clean_out  out  WIDTH  debounced level.
REQ-011 rise_pulse  out  WIDTH  one-cycle pulse on each 0->1 transition of clean_out.
REQ-012 fall_pulse  out  WIDTH  one-cycle pulse on each 1->0 transition of clean_out.

Function
REQ-013 Each channel shall pass async_in through a SYNC_STAGES-deep flop chain, and sync_out shall be the last stage.
REQ-014 sync_out latency shall be exactly SYNC_STAGES rising edges, and the first stage shall be the only flop that samples async_in.
REQ-015 Each channel shall have a counter of CNT_W bits.
REQ-016 On an edge with en=1 and sync_out[i]!=clean_out[i]:
- if cnt[i]==STABLE_CYCLES-1, clean_out[i] shall load sync_out[i] and cnt[i] shall clear;
- otherwise cnt[i] shall increment.
REQ-017 On an edge with en=1 and sync_out[i]==clean_out[i], cnt[i] shall clear to 0.
REQ-018 On an edge with en=0, cnt[i] and clean_out[i] shall hold, while the synchronizer chain keeps shifting.
REQ-019 Any mismatch lasting fewer than STABLE_CYCLES enabled edges shall leave clean_out unchanged, produce no pulse, and leave cnt at 0.
REQ-020 With en tied high, a clean step shall reach clean_out exactly SYNC_STAGES+STABLE_CYCLES edges after the first sampling edge.
REQ-021 rise_pulse[i] and fall_pulse[i] shall be registered and asserted in the same cycle clean_out[i] first shows its new value, for exactly one cycle.
REQ-022 rise_pulse[i] and fall_pulse[i] shall never be high together.
REQ-023 Channels shall be fully independent; simultaneous transitions on several channels shall produce all their pulses in the same cycle.
REQ-024 The counter shall never exceed STABLE_CYCLES-1, and no counter wrap-around shall be possible.

Reset
REQ-025 While rst=1 at an edge, all synchronizer stages, counters, clean_out, rise_pulse and fall_pulse shall load 0.
REQ-026 A reset asserted mid-debounce shall discard the partial count, and a full STABLE_CYCLES count shall be needed after release.
REQ-027 No pulse shall be emitted in the cycle where rst is high, nor as a consequence of clearing clean_out.
REQ-028 After release, an input already high shall produce a normal rise_pulse once it qualifies.

Structure
REQ-029 Default parameter values and the CNT_W derivation shall reside in the shared project constants header used by other io_circuits blocks.
REQ-030 A sub-module debounce_channel (counter, clean flop and pulse flops for one bit) shall be instantiated WIDTH times via generate.
REQ-031 The synchronizer chain shall be built from the codebase's resettable register primitive, one WIDTH-wide register per stage.

Verification
All scenarios use WIDTH=4, SYNC_STAGES=2, STABLE_CYCLES=4, en=1 unless stated otherwise.
REQ-032 Hold rst=1 for 3 edges with async_in=4'hF, then release -> required response:
- outputs are 0 during reset;
- sync_out=4'hF after edge 2;
- clean_out=4'hF and rise_pulse=4'hF after edge 6;
- rise_pulse=0 on edge 7.
REQ-033 Drive async_in[0] high for 3 cycles, then low -> clean_out[0] stays 0 and no pulses occur.
REQ-034 Drive en high one cycle in four while async_in[1] is steadily high -> clean_out[1] rises on the 4th enabled edge after sync_out[1]=1, with a single rise_pulse[1].
REQ-035 Start from clean_out=4'b1000, then drive async_in[2] 0->1 and async_in[3] 1->0 on the same cycle -> rise_pulse[2] and fall_pulse[3] assert in the same cycle.
REQ-036 Apply rst for 1 cycle when cnt[0]=3 -> clean_out[0] stays 0, and the rise occurs 6 edges after release.
REQ-037 Set SYNC_STAGES=3 and STABLE_CYCLES=1, then apply a step input -> clean_out follows after exactly 4 edges.

Source files
------------

// File: rtl/sync_debounce_pkg.sv
// Shared constants for the io_circuits input-conditioning blocks.
// Holds the default debounce parameters and the counter-width derivation so
// every block that filters raw inputs sizes its counters the same way.
package sync_debounce_pkg;

  localparam int DEFAULT_WIDTH         = 1;
  localparam int DEFAULT_SYNC_STAGES   = 2;
  localparam int DEFAULT_STABLE_CYCLES = 4;

  // Counter must hold 0 .. stableCycles-1; one extra code keeps it safe for
  // stableCycles = 1, where a 1-bit counter is still required.
  function automatic int cnt_width(input int stableCycles);
    return $clog2(stableCycles + 1);
  endfunction

endpackage

// File: rtl/sync_debounce_channel.sv
// One debounce lane: a saturating mismatch counter, the filtered level flop
// and the registered rise/fall pulse flops for a single synchronized bit.
module debounce_channel
  import sync_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = cnt_width(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic sync_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(STABLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Next-state: count enabled mismatches, flip the level on the last one and
  // clear the count; any agreement wipes a partial count. The counter stops
  // at LAST_COUNT because that value always triggers the flip and a clear.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en_i) begin
      if (sync_i != clean_q) begin
        if (cnt_q == LAST_COUNT) begin
          clean_d = sync_i;
          cnt_d   = '0;
          rise_d  = sync_i;
          fall_d  = ~sync_i;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // State flops; reset clears the level directly so it never emits a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/sync_debounce_reg.sv
// Resettable register primitive: a WIDTH-wide bank of flops with a
// synchronous active-high clear. Used for every synchronizer stage.
module sync_debounce_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // Plain D register, cleared to zero while rst is high.
  always_ff @(posedge clk) begin
    if (rst) q_o <= '0;
    else     q_o <= d_i;
  end

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel input conditioner: a SYNC_STAGES-deep synchronizer followed
// by an independent debounce lane per bit producing a clean level and
// one-cycle rise/fall pulses. WIDTH >= 1, SYNC_STAGES >= 2, STABLE_CYCLES >= 1.
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = cnt_width(STABLE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  input  logic             en,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  // Slot 0 is the raw input; slot s+1 is the output of stage s, so only the
  // first register ever sees async_in.
  logic [SYNC_STAGES:0][WIDTH-1:0] syncChain;

  assign syncChain[0] = async_in;

  // Synchronizer: one full-width register per stage, shifting every cycle
  // regardless of en.
  for (genvar s = 0; s < SYNC_STAGES; s++) begin : gSync
    sync_debounce_reg #(
      .W(WIDTH)
    ) uStage (
      .clk (clk),
      .rst (rst),
      .d_i (syncChain[s]),
      .q_o (syncChain[s+1])
    );
  end

  assign sync_out = syncChain[SYNC_STAGES];

  // Debounce lanes: fully independent, so simultaneous transitions on
  // several bits produce their pulses in the same cycle.
  for (genvar i = 0; i < WIDTH; i++) begin : gChan
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) uChan (
      .clk     (clk),
      .rst     (rst),
      .en_i    (en),
      .sync_i  (sync_out[i]),
      .clean_o (clean_out[i]),
      .rise_o  (rise_pulse[i]),
      .fall_o  (fall_pulse[i])
    );
  end

endmodule

// File: tb/tb_sync_debounce.sv
// Directed self-checking bench for sync_debounce: a 4-channel instance with
// default timing and a 1-channel instance with SYNC_STAGES=3, STABLE_CYCLES=1.
module tb_sync_debounce;

  logic       clock;
  logic       reset;
  logic       en;
  logic [3:0] asyncIn;
  logic [3:0] syncOut, cleanOut, risePulse, fallPulse;
  logic       asyncB;
  logic       syncB, cleanB, riseB, fallB;

  int checks = 0;
  int errors = 0;

  sync_debounce #(
    .WIDTH(4), .SYNC_STAGES(2), .STABLE_CYCLES(4)
  ) dut (
    .clk        (clock),
    .rst        (reset),
    .async_in   (asyncIn),
    .en         (en),
    .sync_out   (syncOut),
    .clean_out  (cleanOut),
    .rise_pulse (risePulse),
    .fall_pulse (fallPulse)
  );

  sync_debounce #(
    .WIDTH(1), .SYNC_STAGES(3), .STABLE_CYCLES(1)
  ) dutB (
    .clk        (clock),
    .rst        (reset),
    .async_in   (asyncB),
    .en         (1'b1),
    .sync_out   (syncB),
    .clean_out  (cleanB),
    .rise_pulse (riseB),
    .fall_pulse (fallB)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle so outputs are sampled away from it.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] expClean,
                          input logic [3:0] expRise, input logic [3:0] expFall);
    checkOutput({tag, ".clean"}, cleanOut, expClean);
    checkOutput({tag, ".rise"}, risePulse, expRise);
    checkOutput({tag, ".fall"}, fallPulse, expFall);
  endtask

  initial begin
    reset   = 1'b1;
    en      = 1'b1;
    asyncIn = 4'hF;
    asyncB  = 1'b0;

    // Reset held for three edges with all inputs high.
    $display("[TB] reset with inputs high");
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkAll("rst_hold", 4'h0, 4'h0, 4'h0);
      checkOutput("rst_hold.sync", syncOut, 4'h0);
    end
    reset = 1'b0;
    applyStimulus();
    checkOutput("rel_e1.sync", syncOut, 4'h0);
    applyStimulus();
    checkOutput("rel_e2.sync", syncOut, 4'hF);
    for (int i = 3; i <= 5; i++) begin
      applyStimulus();
      checkAll("rel_wait", 4'h0, 4'h0, 4'h0);
    end
    applyStimulus();
    checkAll("rel_e6", 4'hF, 4'hF, 4'h0);
    applyStimulus();
    checkAll("rel_e7", 4'hF, 4'h0, 4'h0);

    // Reset clearing a high clean level must not produce fall pulses.
    $display("[TB] reset clears clean level");
    reset   = 1'b1;
    asyncIn = 4'h0;
    applyStimulus();
    checkAll("rst_clear", 4'h0, 4'h0, 4'h0);
    reset = 1'b0;
    applyStimulus();
    checkAll("rst_clear_after", 4'h0, 4'h0, 4'h0);

    // Three-cycle glitch on channel 0 is filtered out.
    $display("[TB] short glitch on channel 0");
    asyncIn = 4'h1;
    for (int i = 0; i < 3; i++) applyStimulus();
    asyncIn = 4'h0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      checkAll("glitch", 4'h0, 4'h0, 4'h0);
    end

    // Enable one cycle in four with channel 1 steadily high.
    $display("[TB] slow enable on channel 1");
    en      = 1'b0;
    asyncIn = 4'h2;
    applyStimulus();
    applyStimulus();
    checkOutput("slow.sync", syncOut, 4'h2);
    checkOutput("slow.clean0", cleanOut, 4'h0);
    for (int g = 0; g < 4; g++) begin
      en = 1'b1;
      applyStimulus();
      if (g < 3) checkAll("slow_en", 4'h0, 4'h0, 4'h0);
      else       checkAll("slow_en4", 4'h2, 4'h2, 4'h0);
      en = 1'b0;
      for (int k = 0; k < 3; k++) begin
        applyStimulus();
        checkAll("slow_idle", (g < 3) ? 4'h0 : 4'h2, 4'h0, 4'h0);
      end
    end
    en = 1'b1;

    // Establish clean_out = 4'b1000, then swap channels 2 and 3 together.
    $display("[TB] simultaneous rise and fall");
    reset   = 1'b1;
    asyncIn = 4'h8;
    applyStimulus();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus();
    checkAll("pre8_e5", 4'h0, 4'h0, 4'h0);
    applyStimulus();
    checkAll("pre8_e6", 4'h8, 4'h8, 4'h0);
    applyStimulus();
    checkAll("pre8_e7", 4'h8, 4'h0, 4'h0);
    asyncIn = 4'h4;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkAll("swap_wait", 4'h8, 4'h0, 4'h0);
    end
    applyStimulus();
    checkAll("swap_e6", 4'h4, 4'h4, 4'h8);
    applyStimulus();
    checkAll("swap_e7", 4'h4, 4'h0, 4'h0);

    // Reset mid-count discards progress; full count needed after release.
    $display("[TB] reset mid-debounce");
    reset   = 1'b1;
    asyncIn = 4'h0;
    applyStimulus();
    reset   = 1'b0;
    asyncIn = 4'h1;
    for (int i = 0; i < 5; i++) applyStimulus();
    checkAll("mid_cnt3", 4'h0, 4'h0, 4'h0);
    reset = 1'b1;
    applyStimulus();
    checkAll("mid_rst", 4'h0, 4'h0, 4'h0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkAll("mid_wait", 4'h0, 4'h0, 4'h0);
    end
    applyStimulus();
    checkAll("mid_e6", 4'h1, 4'h1, 4'h0);
    applyStimulus();
    checkAll("mid_e7", 4'h1, 4'h0, 4'h0);

    // Three-stage synchronizer with single-cycle qualification.
    $display("[TB] SYNC_STAGES=3 STABLE_CYCLES=1 step");
    asyncB = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("b_e2.sync", {3'b0, syncB}, 4'h0);
    applyStimulus();
    checkOutput("b_e3.sync", {3'b0, syncB}, 4'h1);
    checkOutput("b_e3.clean", {3'b0, cleanB}, 4'h0);
    applyStimulus();
    checkOutput("b_e4.clean", {3'b0, cleanB}, 4'h1);
    checkOutput("b_e4.rise", {3'b0, riseB}, 4'h1);
    checkOutput("b_e4.fall", {3'b0, fallB}, 4'h0);
    applyStimulus();
    checkOutput("b_e5.rise", {3'b0, riseB}, 4'h0);
    checkOutput("b_e5.clean", {3'b0, cleanB}, 4'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
